pico_versat: RTL and testbench

- Minimal 8-bit accumulator controller (picoVersat) that fetches one instruction per cycle from an external instruction port.
- Executes each instruction in a single cycle and reaches peripherals/memory through a simple read/write bus.
- Sits between the program ROM and the peripheral/register bus of the calculator datapath.
- Supports multi-byte arithmetic through a carry register, and stalls while the instruction is not valid.

---
 rtl/pico_versat.sv | 72 +++++++
 tb/tb_pico_versat.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/pico_versat.sv
// pico_versat: 8-bit accumulator controller executing one instruction per cycle
module pico_versat #(
  parameter int DATA_W = 8,
  parameter int OPCODESZ = 4,
  parameter int IMM_W = 8,
  parameter int INSTR_W = OPCODESZ + IMM_W,
  parameter int INT_ADDR_W = 8,
  parameter int IADDR_W = 9
)(
  input  logic                  clk,
  input  logic                  rst,
  output logic [IADDR_W:0]      pc,
  input  logic                  instr_valid,
  input  logic [INSTR_W-1:0]    instruction,
  output logic                  rw_req,
  output logic                  rw_rnw,
  output logic [INT_ADDR_W-1:0] rw_addr,
  input  logic [DATA_W-1:0]     data_to_rd,
  output logic [DATA_W-1:0]     data_to_wr
);
  localparam logic [OPCODESZ-1:0] ADDI = 1, ADD = 2, SUB = 3, LDI = 4, RDW = 5, WRW = 6,
                                  AND = 7, XOR = 8, MUL = 9, BEQI = 12, BNEQI = 13, JMPI = 14;
  logic [INSTR_W-1:0]  instruction_int2, instruction_reg;
  logic [OPCODESZ-1:0] opcode;
  logic [DATA_W-1:0]   imm, regA, data_to_rd_int;
  logic [2*DATA_W-1:0] regB;
  logic                regC;
  logic [DATA_W:0]     add_res, sub_res;
  logic                mem_op, taken, unused;
  // a stalled cycle is executed as an all-zero NOP word
  assign instruction_int2 = instr_valid ? instruction : '0;
  assign opcode = instruction_int2[INSTR_W-1 -: OPCODESZ];
  assign imm = DATA_W'($signed(instruction_int2[IMM_W-1:0]));
  assign rw_addr = instruction_int2[INT_ADDR_W-1:0];
  assign data_to_rd_int = rw_addr == INT_ADDR_W'(0) ? regA :
                          rw_addr == INT_ADDR_W'(1) ? regB[DATA_W-1:0] :
                          rw_addr == INT_ADDR_W'(2) ? DATA_W'(regC) : data_to_rd;
  assign mem_op = opcode inside {ADD, SUB, RDW, WRW, AND, XOR, MUL};
  assign rw_req = !rst && instr_valid && mem_op && rw_addr >= INT_ADDR_W'(3);
  assign rw_rnw = rst || opcode != WRW;
  assign data_to_wr = regA;
  assign add_res = {1'b0, regA} + {1'b0, opcode == ADDI ? imm : data_to_rd_int};
  // carry out of A + ~D + 1 is the inverted borrow
  assign sub_res = {1'b0, regA} + {1'b0, ~data_to_rd_int} + (DATA_W+1)'(1);
  assign taken = opcode == JMPI || (opcode == BEQI && regA == '0) || (opcode == BNEQI && regA != '0);
  assign unused = ^{instruction_reg, regB[2*DATA_W-1:DATA_W]};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      regA <= '0;
      regB <= '0;
      regC <= 1'b0;
      pc <= '0;
      instruction_reg <= '0;
    end else begin
      instruction_reg <= instruction_int2;
      if (instr_valid) pc <= taken ? (IADDR_W+1)'(imm) : pc + (IADDR_W+1)'(1);
      case (opcode)
        ADDI, ADD: {regC, regA} <= add_res;
        SUB: {regC, regA} <= sub_res;
        LDI: regA <= imm;
        RDW: regA <= data_to_rd_int;
        WRW: begin
          if (rw_addr == INT_ADDR_W'(1)) regB <= (2*DATA_W)'(regA);
          if (rw_addr == INT_ADDR_W'(2)) regC <= regA[0];
        end
        AND: regA <= regA & data_to_rd_int;
        XOR: regA <= regA ^ data_to_rd_int;
        MUL: regB <= (2*DATA_W)'(regA) * (2*DATA_W)'(data_to_rd_int);
        default: ;
      endcase
    end
endmodule

// File: tb/tb_pico_versat.sv
// tb_pico_versat: scoreboard bench driving a reference accumulator model
module tb_pico_versat;
  logic clk = 0, rst = 1, instr_valid = 1;
  logic [9:0] pc;
  logic [11:0] instruction = 12'h606;
  logic rw_req, rw_rnw;
  logic [7:0] rw_addr, data_to_rd = 0, data_to_wr;
  int passed = 0, total = 0;
  int ma = 0, mb = 0, mc = 0, mpc = 0;
  typedef struct {int a; int b; int c; int p; int ir;} exp_t;
  exp_t q[$];

  pico_versat dut (.clk(clk), .rst(rst), .pc(pc), .instr_valid(instr_valid), .instruction(instruction),
                   .rw_req(rw_req), .rw_rnw(rw_rnw), .rw_addr(rw_addr), .data_to_rd(data_to_rd),
                   .data_to_wr(data_to_wr));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step(input int v, input int op, input int im, input int rd);
    int eop, ea, d, s;
    bit tk;
    exp_t e;
    @(negedge clk);
    instr_valid = v[0];
    instruction = {op[3:0], im[7:0]};
    data_to_rd = rd[7:0];
    eop = v ? op : 0;
    ea = v ? im : 0;
    d = ea == 0 ? ma : ea == 1 ? mb % 256 : ea == 2 ? mc : rd;
    #1;
    check("rw_req", rw_req, (eop inside {2, 3, 5, 6, 7, 8, 9}) && ea >= 3);
    check("rw_rnw", rw_rnw, eop != 6);
    check("rw_addr", rw_addr, ea);
    check("data_to_wr", data_to_wr, ma);
    check("rd_int", dut.data_to_rd_int, d);
    tk = eop == 14 || (eop == 12 && ma == 0) || (eop == 13 && ma != 0);
    case (eop)
      1: begin s = ma + im; ma = s % 256; mc = s / 256; end
      2: begin s = ma + d; ma = s % 256; mc = s / 256; end
      3: begin s = ma + 256 - d; ma = s % 256; mc = s / 256; end
      4: ma = im;
      5: ma = d;
      6: begin if (ea == 1) mb = ma; if (ea == 2) mc = ma % 2; end
      7: ma = ma & d;
      8: ma = ma ^ d;
      9: mb = ma * d;
      default: ;
    endcase
    if (v) mpc = tk ? im : (mpc + 1) % 1024;
    e = '{a: ma, b: mb, c: mc, p: mpc, ir: v ? (op * 256 + im) : 0};
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check("regA", dut.regA, e.a);
    check("regB", dut.regB, e.b);
    check("regC", dut.regC, e.c);
    check("pc", pc, e.p);
    check("instruction_reg", dut.instruction_reg, e.ir);
  endtask

  initial begin
    #3;
    check("rst_regA", dut.regA, 0);
    check("rst_regB", dut.regB, 0);
    check("rst_regC", dut.regC, 0);
    check("rst_pc", pc, 0);
    check("rst_ireg", dut.instruction_reg, 0);
    check("rst_req", rw_req, 0);
    check("rst_rnw", rw_rnw, 1);
    @(negedge clk);
    instr_valid = 0;
    rst = 0;
    step(1, 4, 3, 0);
    step(1, 6, 6, 0);
    check("plan_wr_req", rw_req, 1);
    step(1, 5, 7, 'h55);
    check("plan_rdw", dut.regA, 'h55);
    step(1, 5, 3, 'hA5);
    step(1, 2, 4, 'hA5);
    check("plan_add_lo", dut.regA, 'h4A);
    check("plan_add_c", dut.regC, 1);
    step(1, 5, 5, 'h5A);
    step(1, 2, 2, 'h00);
    check("plan_add_hi", dut.regA, 'h5B);
    #2 rst = 1;
    instr_valid = 0;
    #1;
    check("async_regA", dut.regA, 0);
    check("async_regC", dut.regC, 0);
    check("async_pc", pc, 0);
    ma = 0; mb = 0; mc = 0; mpc = 0;
    @(negedge clk);
    rst = 0;
    step(1, 5, 3, 'hA5);
    step(1, 3, 4, 'h5A);
    check("plan_sub_lo", dut.regA, 'h4B);
    check("plan_sub_c", dut.regC, 1);
    step(1, 5, 9, 'hA5);
    step(1, 2, 2, 0);
    step(1, 1, 'hFF, 0);
    step(1, 3, 4, 'h5A);
    check("plan_sub_hi", dut.regA, 'h4B);
    step(1, 4, 'hC8, 0);
    step(1, 6, 1, 0);
    step(1, 4, 0, 0);
    step(1, 5, 1, 0);
    step(1, 9, 5, 'hFF);
    check("plan_mul", dut.regB, 'hC738);
    step(1, 6, 2, 0);
    step(1, 7, 3, 'h0F);
    step(1, 8, 3, 'hFF);
    step(1, 6, 0, 0);
    step(1, 15, 3, 0);
    step(1, 1, 'hFF, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 'hFE, 0);
    step(0, 6, 9, 0);
    step(1, 1, 'hFE, 0);
    step(1, 4, 0, 0);
    step(1, 12, 'h20, 0);
    check("plan_beqi", pc, 'h20);
    step(1, 4, 1, 0);
    step(1, 12, 'h40, 0);
    check("plan_beqi_nt", pc, 'h22);
    step(1, 13, 'h30, 0);
    step(1, 14, 'hFF, 0);
    step(1, 0, 0, 0);
    check("plan_jmp_next", pc, 'h100);
    while (mpc != 1023) step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("pc_wrap", pc, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
